// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared types and helpers for the priority round-robin arbiter
package arbiter_pkg;

    localparam int MAX_MASTERS = 32;
    localparam int IDX_W       = $clog2(MAX_MASTERS);

    typedef enum logic {IDLE, BUSY} arb_state_t;

    // OR-reduction of set-bit indices; exact for one-hot or zero inputs.
    function automatic logic [IDX_W-1:0] onehot2bin(input logic [MAX_MASTERS-1:0] oh);
        logic [IDX_W-1:0] b;
        b = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) b = b | IDX_W'(i);
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - wrap-around first-set-bit search starting just above ptr
module rr_pick
    import arbiter_pkg::*;
#(
    parameter int num_master = 4,
    localparam int id_w = $clog2(num_master)
) (
    input  logic [num_master-1:0] mask,
    input  logic [id_w-1:0]       ptr,
    output logic                  found,
    output logic [id_w-1:0]       idx,
    output logic [num_master-1:0] onehot
);

    logic [id_w-1:0] pos;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        pos    = '0;
        onehot = '0;
        // k runs to num_master so ptr itself is the last position examined.
        for (int k = 1; k <= num_master; k++) begin
            pos = id_w'((int'(ptr) + k) % num_master);
            if (!found && mask[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
        if (found) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/prio_rr_arbiter.sv
// rtl/prio_rr_arbiter.sv - registered priority/round-robin arbiter with bounded grant hold
// Optional preemption of low-priority owners by high-priority requesters: ARB_PREEMPT_EN
module prio_rr_arbiter
    import arbiter_pkg::*;
#(
    parameter int num_master = 4,
    parameter int max_hold   = 8,
    localparam int id_w = $clog2(num_master)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [num_master-1:0] req,
    input  logic [num_master-1:0] pri,
    output logic [num_master-1:0] grant,
    output logic                  grant_valid,
    output logic [id_w-1:0]       grant_id
);

    localparam logic [7:0] HOLD_LAST = 8'(max_hold - 1);

    arb_state_t            state, state_d;
    logic [id_w-1:0]       ptr, ptr_d;
    logic [7:0]            hold_cnt, hold_d;
    logic [num_master-1:0] grant_d, mask, cand, pick_oh;
    logic [id_w-1:0]       pick_idx;
    logic                  pick_found, owner_req, rearb;

    assign owner_req = |(req & grant);
`ifdef ARB_PREEMPT_EN
    logic owner_pri, others_pri;
    assign owner_pri  = |(pri & grant);
    assign others_pri = |(req & pri & ~grant);
`endif

    // A still-requesting owner is masked out so expiry/preemption hands off to someone else.
    always_comb begin
        mask  = req;
        rearb = 1'b1;
        if (state == BUSY && owner_req) begin
            mask  = req & ~grant;
            rearb = (hold_cnt == HOLD_LAST);
`ifdef ARB_PREEMPT_EN
            if (!owner_pri && others_pri) rearb = 1'b1;
`endif
        end
    end

    assign cand = (|(mask & pri)) ? (mask & pri) : mask;

    rr_pick #(.num_master(num_master)) u_pick (
        .mask   (cand),
        .ptr    (ptr),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        hold_d  = hold_cnt;
        grant_d = grant;
        if (!rearb) begin
            hold_d = hold_cnt + 8'd1;
        end else if (pick_found) begin
            grant_d = pick_oh;
            ptr_d   = pick_idx;
            hold_d  = '0;
            state_d = BUSY;
        end else if (state == BUSY && owner_req) begin
            hold_d = '0;
        end else begin
            grant_d = '0;
            hold_d  = '0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= id_w'(num_master - 1);
            hold_cnt    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            hold_cnt    <= hold_d;
            grant       <= grant_d;
            grant_valid <= |grant_d;
        end
    end

    assign grant_id = id_w'(onehot2bin(MAX_MASTERS'(grant)));

endmodule
